// File: rtl/spatz_pkg.sv
// Shared types and helpers for the Spatz vector unit lanes.
package spatz_pkg;

  // Lane operations. The fixed-point entries sit alongside the integer ones.
  typedef enum logic [4:0] {
    VADD,
    VSUB,
    VAND,
    VOR,
    VXOR,
    VMIN,
    VMINU,
    VMAX,
    VMAXU,
    VMUL,
    VMACC,
    VSADD,
    VSADDU,
    VSSUB,
    VSSUBU,
    VAADD,
    VAADDU,
    VASUB,
    VASUBU,
    VSMUL
  } op_e;

  // Element width: 8 << value bits.
  typedef enum logic [1:0] {
    EW_8,
    EW_16,
    EW_32,
    EW_64
  } vew_e;

  // Fixed-point rounding mode (vxrm CSR encoding).
  typedef enum logic [1:0] {
    RNU,
    RNE,
    RDN,
    ROD
  } vxrm_e;

  // Rounding increment after a right shift. out_msb is the most significant
  // shifted-out bit, out_rest the OR of the remaining shifted-out bits and
  // lsb the least significant bit that is kept.
  function automatic logic rnd_inc(vxrm_e vxrm, logic out_msb, logic out_rest, logic lsb);
    logic inc;
    unique case (vxrm)
      RNU:     inc = out_msb;
      RNE:     inc = out_msb & (out_rest | lsb);
      RDN:     inc = 1'b0;
      ROD:     inc = ~lsb & (out_msb | out_rest);
      default: inc = 1'b0;
    endcase
    return inc;
  endfunction

  // Operations implemented by the fixed-point SIMD lane.
  function automatic logic op_supported(op_e op);
    return op inside {VMIN, VMINU, VMAX, VMAXU, VMUL, VMACC, VSADD, VSADDU,
                      VSSUB, VSSUBU, VAADD, VAADDU, VASUB, VASUBU, VSMUL};
  endfunction

endpackage

// File: rtl/spatz_simd_elem_fx.sv
// Single-element fixed-point/integer datapath, SEW bits wide. Purely
// combinational; operands follow RVV naming (s1 = vs1/rs1, s2 = vs2, d = vd).
module spatz_simd_elem_fx
  import spatz_pkg::*;
#(
  parameter int unsigned SEW = 8
) (
  input  op_e            op,
  input  vxrm_e          vxrm,
  input  logic [SEW-1:0] s1,
  input  logic [SEW-1:0] s2,
  input  logic [SEW-1:0] d,
  output logic [SEW-1:0] res,
  output logic           sat
);

  localparam logic [SEW-1:0] SMax = {1'b0, {(SEW-1){1'b1}}};
  localparam logic [SEW-1:0] SMin = {1'b1, {(SEW-1){1'b0}}};

  logic           signed_op;
  logic           is_sub;
  logic [SEW:0]   x1, x2;
  logic [SEW:0]   sum;
  logic [2*SEW-1:0] m1, m2, prod;
  logic [SEW:0]   mround;
  logic           lt;

  assign signed_op = op inside {VSADD, VSSUB, VAADD, VASUB, VMIN, VMAX};
  assign is_sub    = op inside {VSSUB, VSSUBU, VASUB, VASUBU};

  // One extra bit holds the exact sum/difference for both signednesses.
  assign x1  = {signed_op & s1[SEW-1], s1};
  assign x2  = {signed_op & s2[SEW-1], s2};
  assign sum = is_sub ? (x2 - x1) : (x2 + x1);

  // Sign-extended operands give the full signed product in 2*SEW bits;
  // its low SEW bits are also the VMUL/VMACC product.
  assign m1   = {{SEW{s1[SEW-1]}}, s1};
  assign m2   = {{SEW{s2[SEW-1]}}, s2};
  assign prod = m1 * m2;

  // VSMUL keeps SEW+1 bits after the shift so the min*min case shows up
  // as a sign overflow after rounding.
  assign mround = prod[2*SEW-1:SEW-1]
                + {{SEW{1'b0}}, rnd_inc(vxrm, prod[SEW-2], |prod[SEW-3:0], prod[SEW-1])};

  assign lt = $signed(x1) < $signed(x2);

  // Per-op result selection and clamp detection.
  always_comb begin
    res = '0;
    sat = 1'b0;
    case (op)
      VSADD, VSSUB: begin
        if (sum[SEW] ^ sum[SEW-1]) begin
          res = sum[SEW] ? SMin : SMax;
          sat = 1'b1;
        end else begin
          res = sum[SEW-1:0];
        end
      end
      VSADDU: begin
        if (sum[SEW]) begin
          res = '1;
          sat = 1'b1;
        end else begin
          res = sum[SEW-1:0];
        end
      end
      VSSUBU: begin
        if (sum[SEW]) begin
          res = '0;
          sat = 1'b1;
        end else begin
          res = sum[SEW-1:0];
        end
      end
      VAADD, VAADDU, VASUB, VASUBU: begin
        res = sum[SEW:1] + SEW'(rnd_inc(vxrm, sum[0], 1'b0, sum[1]));
      end
      VSMUL: begin
        if (mround[SEW] ^ mround[SEW-1]) begin
          res = mround[SEW] ? SMin : SMax;
          sat = 1'b1;
        end else begin
          res = mround[SEW-1:0];
        end
      end
      VMUL:        res = prod[SEW-1:0];
      VMACC:       res = d + prod[SEW-1:0];
      VMIN, VMINU: res = lt ? s1 : s2;
      VMAX, VMAXU: res = lt ? s2 : s1;
      default: ;
    endcase
  end

endmodule

// File: rtl/spatz_simd_lane_fx.sv
// Packed fixed-point SIMD lane: per-SEW element arrays in front of an
// elastic valid/ready result pipeline, with tag passthrough, flush and a
// sticky saturation flag.
module spatz_simd_lane_fx
  import spatz_pkg::*;
#(
  parameter int unsigned Width       = 64,
  parameter int unsigned NumPipeRegs = 2,
  parameter int unsigned TagWidth    = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  op_e                 operation_i,
  input  vew_e                sew_i,
  input  logic [1:0]          vxrm_i,
  input  logic [Width-1:0]    op_s1_i,
  input  logic [Width-1:0]    op_s2_i,
  input  logic [Width-1:0]    op_d_i,
  input  logic [TagWidth-1:0] tag_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic                flush_i,
  output logic [Width-1:0]    result_o,
  output logic [TagWidth-1:0] result_tag_o,
  output logic                result_sat_o,
  output logic                result_err_o,
  output logic                result_valid_o,
  input  logic                result_ready_i,
  output logic                vxsat_o,
  input  logic                vxsat_clr_i
);

  localparam int unsigned Last   = NumPipeRegs - 1;
  localparam vew_e        MaxSew = (Width >= 64) ? EW_64 : EW_32;

  vxrm_e vxrm;
  assign vxrm = vxrm_e'(vxrm_i);

  // ---------------------------------------------------------------------
  // Compute: one element array per legal SEW, selected by sew_i
  // ---------------------------------------------------------------------
  logic [3:0][Width-1:0] res_by_sew;
  logic [3:0]            sat_by_sew;

  for (genvar g = 0; g < 4; g++) begin : g_sew
    localparam int unsigned SEW = 8 << g;
    if (SEW <= Width) begin : g_legal
      localparam int unsigned N = Width / SEW;
      logic [Width-1:0] res_w;
      logic [N-1:0]     sat_w;
      for (genvar e = 0; e < N; e++) begin : g_elem
        spatz_simd_elem_fx #(
          .SEW (SEW)
        ) u_elem (
          .op   (operation_i),
          .vxrm (vxrm),
          .s1   (op_s1_i[e*SEW +: SEW]),
          .s2   (op_s2_i[e*SEW +: SEW]),
          .d    (op_d_i[e*SEW +: SEW]),
          .res  (res_w[e*SEW +: SEW]),
          .sat  (sat_w[e])
        );
      end
      assign res_by_sew[g] = res_w;
      assign sat_by_sew[g] = |sat_w;
    end else begin : g_illegal
      assign res_by_sew[g] = '0;
      assign sat_by_sew[g] = 1'b0;
    end
  end

  logic             comp_err;
  logic [Width-1:0] comp_data;
  logic             comp_sat;

  assign comp_err  = (sew_i > MaxSew) | ~op_supported(operation_i);
  assign comp_data = comp_err ? '0 : res_by_sew[sew_i];
  assign comp_sat  = ~comp_err & sat_by_sew[sew_i];

  // ---------------------------------------------------------------------
  // Elastic result pipeline
  // ---------------------------------------------------------------------
  logic [NumPipeRegs-1:0] vld_q;
  logic [NumPipeRegs-1:0] load;
  logic [Width-1:0]       data_q [NumPipeRegs];
  logic [TagWidth-1:0]    tag_q  [NumPipeRegs];
  logic [NumPipeRegs-1:0] sat_q;
  logic [NumPipeRegs-1:0] err_q;
  logic                   accept;

  // A stage loads when it is empty or everything downstream of it moves;
  // the scalar chain walks from the consumer back to stage 0.
  always_comb begin
    logic chain;
    load  = '0;
    chain = result_ready_i;
    for (int unsigned i = 0; i < NumPipeRegs; i++) begin
      chain          = ~vld_q[Last-i] | chain;
      load[Last-i]   = chain;
    end
  end

  assign in_ready_o = load[0] & ~flush_i;
  assign accept     = in_valid_i & in_ready_o;

  // Stage registers: shift forward on load, drop everything on flush.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= '0;
      sat_q <= '0;
      err_q <= '0;
      for (int unsigned k = 0; k < NumPipeRegs; k++) begin
        data_q[k] <= '0;
        tag_q[k]  <= '0;
      end
    end else if (flush_i) begin
      vld_q <= '0;
    end else begin
      if (load[0]) begin
        vld_q[0] <= accept;
        if (accept) begin
          data_q[0] <= comp_data;
          tag_q[0]  <= tag_i;
          sat_q[0]  <= comp_sat;
          err_q[0]  <= comp_err;
        end
      end
      for (int unsigned k = 1; k < NumPipeRegs; k++) begin
        if (load[k]) begin
          vld_q[k] <= vld_q[k-1];
          if (vld_q[k-1]) begin
            data_q[k] <= data_q[k-1];
            tag_q[k]  <= tag_q[k-1];
            sat_q[k]  <= sat_q[k-1];
            err_q[k]  <= err_q[k-1];
          end
        end
      end
    end
  end

  assign result_valid_o = vld_q[Last];
  assign result_o       = data_q[Last];
  assign result_tag_o   = tag_q[Last];
  assign result_sat_o   = sat_q[Last];
  assign result_err_o   = err_q[Last];

  // ---------------------------------------------------------------------
  // Sticky saturation flag
  // ---------------------------------------------------------------------
  logic vxsat_set;

  // A result dropped by a flush in its handshake cycle does not count.
  assign vxsat_set = result_valid_o & result_ready_i & result_sat_o & ~flush_i;

  // Set has priority over a same-cycle clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vxsat_o <= 1'b0;
    end else if (vxsat_set) begin
      vxsat_o <= 1'b1;
    end else if (vxsat_clr_i) begin
      vxsat_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spatz_simd_lane_fx.sv
// Scoreboard bench for spatz_simd_lane_fx (Width=32, NumPipeRegs=3).
module tb_spatz_simd_lane_fx;
  import spatz_pkg::*;

  localparam int unsigned W  = 32;
  localparam int unsigned NP = 3;
  localparam int unsigned TW = 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  op_e           operation_i;
  vew_e          sew_i;
  logic [1:0]    vxrm_i;
  logic [W-1:0]  op_s1_i, op_s2_i, op_d_i;
  logic [TW-1:0] tag_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic          flush_i;
  logic [W-1:0]  result_o;
  logic [TW-1:0] result_tag_o;
  logic          result_sat_o;
  logic          result_err_o;
  logic          result_valid_o;
  logic          result_ready_i;
  logic          vxsat_o;
  logic          vxsat_clr_i;

  spatz_simd_lane_fx #(
    .Width       (W),
    .NumPipeRegs (NP),
    .TagWidth    (TW)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .operation_i    (operation_i),
    .sew_i          (sew_i),
    .vxrm_i         (vxrm_i),
    .op_s1_i        (op_s1_i),
    .op_s2_i        (op_s2_i),
    .op_d_i         (op_d_i),
    .tag_i          (tag_i),
    .in_valid_i     (in_valid_i),
    .in_ready_o     (in_ready_o),
    .flush_i        (flush_i),
    .result_o       (result_o),
    .result_tag_o   (result_tag_o),
    .result_sat_o   (result_sat_o),
    .result_err_o   (result_err_o),
    .result_valid_o (result_valid_o),
    .result_ready_i (result_ready_i),
    .vxsat_o        (vxsat_o),
    .vxsat_clr_i    (vxsat_clr_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [W-1:0]  data;
    logic [TW-1:0] tag;
    logic          sat;
    logic          err;
  } exp_t;

  exp_t          sb[$];
  int            n_vec = 0;
  int            n_err = 0;
  logic [TW-1:0] tag_cnt = '0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Monitor: samples 1 time unit after the falling edge, when inputs for
  // the next rising edge are settled.
  logic          held = 1'b0;
  logic [W-1:0]  h_data;
  logic [TW-1:0] h_tag;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      #1;
      if (rst_i) begin
        held = 1'b0;
      end else begin
        if (held) begin
          check("stall_valid", result_valid_o, 1);
          check("stall_data",  result_o, h_data);
          check("stall_tag",   result_tag_o, h_tag);
        end
        if (result_valid_o && result_ready_i) begin
          if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_result: got tag %0d data 0x%0h, expected none", result_tag_o, result_o);
          end else begin
            e = sb.pop_front();
            check($sformatf("data_tag%0d", e.tag), result_o, e.data);
            check($sformatf("tag_tag%0d",  e.tag), result_tag_o, e.tag);
            check($sformatf("sat_tag%0d",  e.tag), result_sat_o, e.sat);
            check($sformatf("err_tag%0d",  e.tag), result_err_o, e.err);
          end
        end
        held   = result_valid_o && !result_ready_i;
        h_data = result_o;
        h_tag  = result_tag_o;
      end
    end
  end

  task automatic drive(input op_e op, input vew_e sew, input logic [1:0] rm,
                       input logic [W-1:0] s1, input logic [W-1:0] s2, input logic [W-1:0] d);
    operation_i = op;
    sew_i       = sew;
    vxrm_i      = rm;
    op_s1_i     = s1;
    op_s2_i     = s2;
    op_d_i      = d;
    tag_i       = tag_cnt;
    in_valid_i  = 1'b1;
  endtask

  // Present one op and wait (bounded) for acceptance; leaves in_valid_i high.
  task automatic issue(input op_e op, input vew_e sew, input logic [1:0] rm,
                       input logic [W-1:0] s1, input logic [W-1:0] s2, input logic [W-1:0] d,
                       input logic [W-1:0] ed, input logic es, input logic ee, input bit track);
    bit done = 1'b0;
    @(negedge clk_i);
    drive(op, sew, rm, s1, s2, d);
    for (int c = 0; c < 50 && !done; c++) begin
      #1;
      if (in_ready_o) begin
        if (track) sb.push_back('{ed, tag_cnt, es, ee});
        tag_cnt++;
        done = 1'b1;
        @(posedge clk_i);
      end else begin
        @(negedge clk_i);
      end
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL issue_timeout: got no in_ready_o, expected accept");
    end
  endtask

  task automatic drain();
    @(negedge clk_i);
    in_valid_i = 1'b0;
    for (int c = 0; c < 100 && sb.size() != 0; c++) @(negedge clk_i);
    check("drain_empty", sb.size(), 0);
    repeat (2) @(negedge clk_i);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1);
  end

  initial begin
    int k;
    int n;
    int seen;
    rst_i          = 1'b1;
    operation_i    = VADD;
    sew_i          = EW_8;
    vxrm_i         = 2'd0;
    op_s1_i        = '0;
    op_s2_i        = '0;
    op_d_i         = '0;
    tag_i          = '0;
    in_valid_i     = 1'b0;
    flush_i        = 1'b0;
    result_ready_i = 1'b1;
    vxsat_clr_i    = 1'b0;

    // Reset state
    repeat (2) @(negedge clk_i);
    #1;
    check("rst_valid", result_valid_o, 0);
    check("rst_data",  result_o, 0);
    check("rst_tag",   result_tag_o, 0);
    check("rst_sat",   result_sat_o, 0);
    check("rst_err",   result_err_o, 0);
    check("rst_vxsat", vxsat_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Saturating add, vxsat set then cleared
    issue(VSADD, EW_8, 2'd0, 32'h01010101, 32'h7F7F7F7F, '0, 32'h7F7F7F7F, 1, 0, 1);
    drain();
    check("vxsat_set", vxsat_o, 1);
    vxsat_clr_i = 1'b1;
    @(negedge clk_i);
    vxsat_clr_i = 1'b0;
    #1;
    check("vxsat_clr", vxsat_o, 0);

    // Directed vectors (op, sew, vxrm, s1, s2, d, expected data, sat, err)
    issue(VSADD,  EW_8,  2'd0, 32'h01020304, 32'h10203040, '0, 32'h11223344, 0, 0, 1);
    issue(VSADD,  EW_8,  2'd0, 32'h80808080, 32'hFFFFFFFF, '0, 32'h80808080, 1, 0, 1);
    issue(VSADDU, EW_16, 2'd0, 32'hFFFF0001, 32'h00020001, '0, 32'hFFFF0002, 1, 0, 1);
    issue(VSSUBU, EW_8,  2'd0, 32'h06010000, 32'h05050505, '0, 32'h00040505, 1, 0, 1);
    issue(VSSUB,  EW_32, 2'd0, 32'h00000001, 32'h80000000, '0, 32'h80000000, 1, 0, 1);
    issue(VAADDU, EW_8,  2'd0, 32'h00000000, 32'h00000003, '0, 32'h00000002, 0, 0, 1);
    issue(VAADDU, EW_8,  2'd1, 32'h00000000, 32'h00000003, '0, 32'h00000002, 0, 0, 1);
    issue(VAADDU, EW_8,  2'd2, 32'h00000000, 32'h00000003, '0, 32'h00000001, 0, 0, 1);
    issue(VAADDU, EW_8,  2'd3, 32'h00000000, 32'h00000003, '0, 32'h00000001, 0, 0, 1);
    issue(VAADD,  EW_8,  2'd0, 32'h000000FE, 32'h000000FF, '0, 32'h000000FF, 0, 0, 1);
    issue(VASUBU, EW_8,  2'd2, 32'h00000003, 32'h00000001, '0, 32'h000000FF, 0, 0, 1);
    issue(VSMUL,  EW_16, 2'd0, 32'h80004000, 32'h80004000, '0, 32'h7FFF2000, 1, 0, 1);
    issue(VSMUL,  EW_16, 2'd0, 32'h00004000, 32'h00004000, '0, 32'h00002000, 0, 0, 1);
    issue(VSMUL,  EW_8,  2'd0, 32'h00000003, 32'h00000040, '0, 32'h00000002, 0, 0, 1);
    issue(VSMUL,  EW_8,  2'd2, 32'h00000003, 32'h00000040, '0, 32'h00000001, 0, 0, 1);
    issue(VMUL,   EW_8,  2'd0, 32'h1003FF02, 32'h1005FF03, '0, 32'h000F0106, 0, 0, 1);
    issue(VMACC,  EW_16, 2'd0, 32'h00020003, 32'h00030004, 32'h00010002, 32'h0007000E, 0, 0, 1);
    issue(VMIN,   EW_8,  2'd0, 32'h80017F00, 32'h7F02FFFF, '0, 32'h8001FFFF, 0, 0, 1);
    issue(VMINU,  EW_8,  2'd0, 32'h80017F00, 32'h7F02FFFF, '0, 32'h7F017F00, 0, 0, 1);
    issue(VMAX,   EW_8,  2'd0, 32'h80017F00, 32'h7F02FFFF, '0, 32'h7F027F00, 0, 0, 1);
    issue(VMAXU,  EW_8,  2'd0, 32'h80017F00, 32'h7F02FFFF, '0, 32'h8002FFFF, 0, 0, 1);
    issue(VSADD,  EW_64, 2'd0, 32'h01010101, 32'h7F7F7F7F, '0, 32'h00000000, 0, 1, 1);
    issue(VADD,   EW_8,  2'd0, 32'h01010101, 32'h01010101, '0, 32'h00000000, 0, 1, 1);
    drain();

    // Flush two in-flight saturating ops: nothing emerges, vxsat untouched
    vxsat_clr_i = 1'b1;
    @(negedge clk_i);
    vxsat_clr_i = 1'b0;
    #1;
    check("pre_flush_vxsat", vxsat_o, 0);
    issue(VSADD, EW_8, 2'd0, 32'h7F7F7F7F, 32'h7F7F7F7F, '0, '0, 0, 0, 0);
    issue(VSADD, EW_8, 2'd0, 32'h7F7F7F7F, 32'h7F7F7F7F, '0, '0, 0, 0, 0);
    @(negedge clk_i);
    in_valid_i = 1'b1;
    flush_i    = 1'b1;
    #1;
    check("flush_in_ready", in_ready_o, 0);
    @(negedge clk_i);
    flush_i    = 1'b0;
    in_valid_i = 1'b0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (result_valid_o) seen++;
      @(negedge clk_i);
    end
    check("flush_no_valid", seen, 0);
    check("flush_vxsat", vxsat_o, 0);

    // Latency after flush
    issue(VMAXU, EW_8, 2'd0, 32'h01020304, 32'h04030201, '0, 32'h04030304, 0, 0, 1);
    @(negedge clk_i);
    in_valid_i = 1'b0;
    #1;
    n = 1;
    while (!result_valid_o && n < 20) begin
      @(negedge clk_i);
      #1;
      n++;
    end
    check("latency", n, NP);
    drain();

    // Backpressure: 5 tagged ops against a stalled consumer
    tag_cnt        = '0;
    result_ready_i = 1'b0;
    k = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_i);
      drive(VSADD, EW_8, 2'd0, 32'h01010101 * k, 32'h10101010, '0);
      #1;
      if (in_ready_o) begin
        sb.push_back('{32'h10101010 + 32'h01010101 * k, tag_cnt, 1'b0, 1'b0});
        tag_cnt++;
        k++;
      end
    end
    check("bp_accepted", k, NP);
    check("bp_in_ready", in_ready_o, 0);
    for (int c = 0; c < 20 && k < 5; c++) begin
      @(negedge clk_i);
      result_ready_i = 1'b1;
      drive(VSADD, EW_8, 2'd0, 32'h01010101 * k, 32'h10101010, '0);
      #1;
      if (in_ready_o) begin
        sb.push_back('{32'h10101010 + 32'h01010101 * k, tag_cnt, 1'b0, 1'b0});
        tag_cnt++;
        k++;
      end
    end
    check("bp_all_accepted", k, 5);
    drain();

    // Mid-stream async reset with vxsat set and stalled results in flight
    issue(VSSUB, EW_32, 2'd0, 32'h00000001, 32'h80000000, '0, 32'h80000000, 1, 0, 1);
    drain();
    check("pre_rst_vxsat", vxsat_o, 1);
    result_ready_i = 1'b0;
    issue(VSADD, EW_8, 2'd0, 32'h7F7F7F7F, 32'h7F7F7F7F, '0, '0, 0, 0, 0);
    issue(VSADD, EW_8, 2'd0, 32'h7F7F7F7F, 32'h7F7F7F7F, '0, '0, 0, 0, 0);
    @(negedge clk_i);
    in_valid_i = 1'b0;
    repeat (3) @(negedge clk_i);
    #1;
    check("pre_rst_valid", result_valid_o, 1);
    #2;
    rst_i = 1'b1;
    #1;
    check("arst_valid", result_valid_o, 0);
    check("arst_data",  result_o, 0);
    check("arst_tag",   result_tag_o, 0);
    check("arst_sat",   result_sat_o, 0);
    check("arst_vxsat", vxsat_o, 0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i          = 1'b0;
    result_ready_i = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (result_valid_o) seen++;
      @(negedge clk_i);
    end
    check("post_rst_no_stale", seen, 0);
    issue(VMIN, EW_16, 2'd0, 32'h80000005, 32'h7FFF0003, '0, 32'h80000003, 0, 0, 1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
